// File: rtl/maze_pkg.sv
// Shared maze geometry and player FSM encoding for the ROM arbiter.
// Cell index is x + y*MAZE_W.
package maze_pkg;
  localparam int MAZE_W = 48;
  localparam int MAZE_H = 48;
  localparam int MAZE_ADDR_W = 12;
  localparam logic [MAZE_ADDR_W-1:0] END_ADDR = 12'd2110;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_WAIT = 2'd1,
    P_DATA = 2'd2
  } p_state_t;
endpackage

// File: rtl/rom_tag_pipe.sv
// Owner tags travelling alongside an in-flight ROM read.
// Depth equals ROM latency so the tag exits with the data.
module rom_tag_pipe #(
  parameter int LAT = 1
) (
  input  logic div_clk,
  input  logic rst,
  input  logic in_v,
  input  logic in_p,
  output logic out_v,
  output logic out_p
);
  logic [LAT-1:0] v_sr;
  logic [LAT-1:0] p_sr;

  always_ff @(posedge div_clk) begin
    if (rst) begin
      v_sr <= '0;
      p_sr <= '0;
    end else begin
      v_sr[0] <= in_v;
      p_sr[0] <= in_p;
      for (int i = 1; i < LAT; i++) begin
        v_sr[i] <= v_sr[i-1];
        p_sr[i] <= p_sr[i-1];
      end
    end
  end

  assign out_v = v_sr[LAT-1];
  assign out_p = p_sr[LAT-1];
endmodule

// File: rtl/maze_rom_arbiter.sv
// Shares one maze ROM between video fetch and player lookups.
// Video has priority; a starvation counter bounds player wait.
module maze_rom_arbiter
  import maze_pkg::*;
#(
  parameter int ADDR_W = MAZE_ADDR_W,
  parameter int DATA_W = 1,
  parameter int ROM_LAT = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              div_clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_q,
  output logic              vid_valid,
  output logic              vid_stall,
  input  logic              pl_req,
  input  logic [ADDR_W-1:0] pl_addr,
  output logic              pl_busy,
  output logic              pl_done,
  output logic [DATA_W-1:0] pl_q,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  p_state_t          state;
  logic [ADDR_W-1:0] p_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              grant_p;
  logic              grant_v;
  logic              tag_v;
  logic              tag_p;

  assign grant_p = !rst && (state == P_WAIT)
                && (!vid_req || wait_cnt == LIMIT);
  assign grant_v = !rst && vid_req && !grant_p;
  assign vid_stall = vid_req && grant_p;

  // busy covers the done cycle so it stays high across chained requests
  assign pl_busy = (state != P_IDLE) || pl_done;

  always_comb begin
    rom_addr = last_addr;
    unique case (1'b1)
      rst:     rom_addr = '0;
      grant_p: rom_addr = p_addr;
      grant_v: rom_addr = vid_addr;
      default: ;
    endcase
  end

  always_ff @(posedge div_clk) begin
    if (rst) last_addr <= '0;
    else     last_addr <= rom_addr;
  end

  rom_tag_pipe #(
    .LAT(ROM_LAT)
  ) u_tags (
    .div_clk(div_clk),
    .rst    (rst),
    .in_v   (grant_v),
    .in_p   (grant_p),
    .out_v  (tag_v),
    .out_p  (tag_p)
  );

  always_ff @(posedge div_clk) begin
    if (rst) begin
      vid_q     <= '0;
      vid_valid <= 1'b0;
    end else begin
      vid_valid <= tag_v;
      if (tag_v) vid_q <= rom_q;
    end
  end

  always_ff @(posedge div_clk) begin
    if (rst) begin
      state    <= P_IDLE;
      wait_cnt <= '0;
      p_addr   <= '0;
      pl_q     <= '0;
      pl_done  <= 1'b0;
    end else begin
      pl_done <= 1'b0;
      unique case (state)
        P_IDLE: begin
          if (pl_req) begin
            p_addr   <= pl_addr;
            wait_cnt <= '0;
            state    <= P_WAIT;
          end
        end
        P_WAIT: begin
          if (grant_p)
            state <= P_DATA;
          else if (wait_cnt != LIMIT)
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
        P_DATA: begin
          if (tag_p) begin
            pl_q    <= rom_q;
            pl_done <= 1'b1;
            state   <= P_IDLE;
          end
        end
        default: state <= P_IDLE;
      endcase
    end
  end
endmodule
